// File: rtl/rggen_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rggen_irq_arbiter
// Brief    : Masks interrupt status with enable, arbitrates one winner and
//            tracks it through request / acknowledge / end-of-interrupt.
// Revision : 1.0
// ============================================================================
module rggen_irq_arbiter #(
    parameter int TOTAL_INTERRUPTS = 8,
    parameter int ROUND_ROBIN      = 1,
    localparam int ID_WIDTH        = (TOTAL_INTERRUPTS > 1) ? $clog2(TOTAL_INTERRUPTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
    input  logic [TOTAL_INTERRUPTS-1:0] i_isr,
    output logic                        o_irq,
    output logic [ID_WIDTH-1:0]         o_irq_id,
    input  logic                        i_ack,
    input  logic                        i_eoi,
    output logic                        o_in_service,
    output logic [TOTAL_INTERRUPTS-1:0] o_pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Pointer starts at the top index so that index 0 is searched first.
    localparam logic [ID_WIDTH-1:0] c_PTR_RST = ID_WIDTH'(TOTAL_INTERRUPTS - 1);

    state_e                      state_q, state_d;
    logic                        irq_q, irq_d;
    logic [ID_WIDTH-1:0]         irq_id_q, irq_id_d;
    logic                        in_service_q, in_service_d;
    logic [TOTAL_INTERRUPTS-1:0] pending_q, pending_d;
    logic [ID_WIDTH-1:0]         ptr_q, ptr_d;

    logic [TOTAL_INTERRUPTS-1:0] w_pending;
    logic [ID_WIDTH-1:0]         w_winner;
    logic                        w_found;

    assign w_pending = i_ier & i_isr;

    // Round-robin visits ptr+1 .. ptr (wrapping); fixed priority visits 0 .. N-1.
    always_comb begin
        int idx;
        w_winner = '0;
        w_found  = 1'b0;
        idx      = 0;
        for (int k = 0; k < TOTAL_INTERRUPTS; k++) begin
            if (ROUND_ROBIN != 0) begin
                idx = (int'(ptr_q) + 1 + k) % TOTAL_INTERRUPTS;
            end else begin
                idx = k;
            end
            if (!w_found && w_pending[idx]) begin
                w_winner = ID_WIDTH'(idx);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        ptr_d        = ptr_q;
        pending_d    = w_pending;

        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    irq_id_d = w_winner;
                    irq_d    = 1'b1;
                    state_d  = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // Acknowledge takes precedence over a simultaneous withdrawal.
                if (i_ack) begin
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                    ptr_d        = irq_id_q;
                    state_d      = ST_SERVICE;
                end else if (!w_pending[irq_id_q]) begin
                    irq_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (i_eoi) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                irq_d        = 1'b0;
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
            pending_q    <= '0;
            ptr_q        <= c_PTR_RST;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
        end
    end

    assign o_irq        = irq_q;
    assign o_irq_id     = irq_id_q;
    assign o_in_service = in_service_q;
    assign o_pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_rggen_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rggen_irq_arbiter
// Brief    : Directed vector table on a round-robin instance plus hand-written
//            sequences on a fixed-priority instance.
// Revision : 1.0
// ============================================================================
module tb_rggen_irq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] ier, isr;
    logic       ack, eoi;
    logic       irq, in_svc;
    logic [2:0] irq_id;
    logic [7:0] pend;

    logic [7:0] f_ier, f_isr;
    logic       f_ack, f_eoi;
    logic       f_irq, f_in_svc;
    logic [2:0] f_irq_id;
    logic [7:0] f_pend;

    int checks = 0;
    int errors = 0;

    rggen_irq_arbiter #(.TOTAL_INTERRUPTS(8), .ROUND_ROBIN(1)) u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ier        (ier),
        .i_isr        (isr),
        .o_irq        (irq),
        .o_irq_id     (irq_id),
        .i_ack        (ack),
        .i_eoi        (eoi),
        .o_in_service (in_svc),
        .o_pending    (pend)
    );

    rggen_irq_arbiter #(.TOTAL_INTERRUPTS(8), .ROUND_ROBIN(0)) u_fp (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ier        (f_ier),
        .i_isr        (f_isr),
        .o_irq        (f_irq),
        .o_irq_id     (f_irq_id),
        .i_ack        (f_ack),
        .i_eoi        (f_eoi),
        .o_in_service (f_in_svc),
        .o_pending    (f_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] ier;
        logic [7:0] isr;
        logic       ack;
        logic       eoi;
        logic       irq;
        logic [2:0] id;
        logic       svc;
        logic [7:0] pend;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic r, input logic [7:0] e, input logic [7:0] s,
                       input logic a, input logic o, input logic xi,
                       input logic [2:0] xid, input logic xs, input logic [7:0] xp);
        vec_t v;
        v.rst_n = r; v.ier = e; v.isr = s; v.ack = a; v.eoi = o;
        v.irq = xi; v.id = xid; v.svc = xs; v.pend = xp;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; ier = 8'hFF; isr = 8'hFF; ack = 1'b0; eoi = 1'b0;
        f_ier = 8'h00; f_isr = 8'h00; f_ack = 1'b0; f_eoi = 1'b0;

        //   rst  ier    isr    ack  eoi  irq  id  svc  pend
        // Reset held three cycles with everything pending
        add(0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        // Basic flow: 2 then 5
        add(1, 8'hFF, 8'h24, 0, 0, 1, 2, 0, 8'h24);
        add(1, 8'hFF, 8'h24, 1, 0, 0, 2, 1, 8'h24);
        add(1, 8'hFF, 8'h20, 0, 0, 0, 2, 1, 8'h20);
        add(1, 8'hFF, 8'h20, 0, 1, 0, 2, 0, 8'h20);
        add(1, 8'hFF, 8'h20, 0, 0, 1, 5, 0, 8'h20);
        add(1, 8'hFF, 8'h20, 1, 0, 0, 5, 1, 8'h20);
        add(1, 8'hFF, 8'h00, 0, 1, 0, 5, 0, 8'h00);
        // Reset restores pointer; round-robin 0,7,0,7 on 8'h81
        add(0, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'hFF, 8'h81, 0, 0, 1, 0, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 1, 0, 0, 0, 1, 8'h81);
        add(1, 8'hFF, 8'h81, 0, 1, 0, 0, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 0, 0, 1, 7, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 1, 0, 0, 7, 1, 8'h81);
        add(1, 8'hFF, 8'h81, 0, 1, 0, 7, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 0, 0, 1, 0, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 1, 0, 0, 0, 1, 8'h81);
        add(1, 8'hFF, 8'h81, 0, 1, 0, 0, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 0, 0, 1, 7, 0, 8'h81);
        add(1, 8'hFF, 8'h81, 1, 0, 0, 7, 1, 8'h81);
        add(1, 8'hFF, 8'h00, 0, 1, 0, 7, 0, 8'h00);
        // Withdraw before ack, then withdraw together with ack
        add(1, 8'hFF, 8'h08, 0, 0, 1, 3, 0, 8'h08);
        add(1, 8'hF7, 8'h08, 0, 0, 0, 3, 0, 8'h00);
        add(1, 8'hF7, 8'h08, 0, 0, 0, 3, 0, 8'h00);
        add(1, 8'hFF, 8'h08, 0, 0, 1, 3, 0, 8'h08);
        add(1, 8'hF7, 8'h08, 1, 0, 0, 3, 1, 8'h00);
        add(1, 8'hF7, 8'h08, 0, 1, 0, 3, 0, 8'h00);
        // Reset in SERVICE with id 6, then re-arbitrate from reset pointer
        add(1, 8'hFF, 8'h40, 0, 0, 1, 6, 0, 8'h40);
        add(1, 8'hFF, 8'h40, 1, 0, 0, 6, 1, 8'h40);
        add(0, 8'hFF, 8'h41, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'hFF, 8'h41, 0, 0, 1, 0, 0, 8'h41);
        // ack+eoi in REQUEST is ack only; ack in SERVICE and IDLE ignored
        add(1, 8'hFF, 8'h41, 1, 1, 0, 0, 1, 8'h41);
        add(1, 8'hFF, 8'h41, 1, 0, 0, 0, 1, 8'h41);
        add(1, 8'hFF, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        add(1, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 8'h00);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; ier = vecs[i].ier; isr = vecs[i].isr;
            ack = vecs[i].ack; eoi = vecs[i].eoi;
            tick();
            chk($sformatf("vec%0d {irq,id,svc,pend}", i),
                {19'd0, irq, irq_id, in_svc, pend},
                {19'd0, vecs[i].irq, vecs[i].id, vecs[i].svc, vecs[i].pend});
        end
        ack = 1'b0; eoi = 1'b0; isr = 8'h00;

        // Fixed priority: 8'h81 always grants index 0
        f_ier = 8'hFF; f_isr = 8'h81;
        tick();
        chk("fp_first_latency", {31'd0, f_irq}, 32'd1);
        for (int n = 0; n < 4; n++) begin
            int   waited;
            waited = 0;
            while (!f_irq && waited < 5) begin
                tick();
                waited++;
            end
            chk($sformatf("fp_irq_raised%0d", n), {31'd0, f_irq}, 32'd1);
            chk($sformatf("fp_irq_id%0d", n), {29'd0, f_irq_id}, 32'd0);
            f_ack = 1'b1;
            tick();
            f_ack = 1'b0;
            chk($sformatf("fp_in_service%0d", n), {30'd0, f_in_svc, f_irq}, 32'd2);
            tick();
            chk($sformatf("fp_no_preempt%0d", n), {30'd0, f_in_svc, f_irq}, 32'd2);
            f_eoi = 1'b1;
            tick();
            f_eoi = 1'b0;
            chk($sformatf("fp_eoi_idle%0d", n), {30'd0, f_in_svc, f_irq}, 32'd0);
        end

        // Withdraw on fixed-priority instance: o_in_service must never rise
        tick();
        chk("fp_req_id0", {28'd0, f_irq, f_irq_id}, {28'd0, 1'b1, 3'd0});
        f_isr = 8'h00;
        tick();
        chk("fp_withdraw_irq", {31'd0, f_irq}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("fp_withdraw_quiet%0d", n), {30'd0, f_in_svc, f_irq}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
